cxapbasyncbridge_master_domain: RTL and testbench
=================================================

Name: cxapbasyncbridge_master_domain

Overview:
Master-interface half of the APB asynchronous bridge. It runs in the destination (master) clock domain. It receives the inter-domain request and forward payload from the slave-side half, runs one APB3 transfer on the downstream bus, and returns the read data and error response with a four-phase acknowledge. It is the direct consumer of apbm_req_async/apbm_fwd_data_async and the producer of apbm_ack_async/apbm_rev_data_async.

Parameters:
ADDR_WIDTH, 32, APB address width; forward payload bits [FWD_W-1 -: ADDR_WIDTH].
DATA_WIDTH, 32, APB data width; FWD_W = ADDR_WIDTH+DATA_WIDTH+1 (65), REV_W = DATA_WIDTH+1 (33).

Ports:
pclkm  in  1  master-domain APB clock; single clock for the block
presetm  in  1  synchronous, active-high reset
pclkenm  in  1  APB clock enable; the FSM and all payload/APB registers advance only when it is 1
apbm_req_async  in  1  request from the slave domain (asynchronous)
apbm_fwd_data_async  in  FWD_W  {paddr, pwdata, pwrite}; stable while req is high
apbm_ack_async  out  1  registered acknowledge to the slave domain
apbm_rev_data_async  out  REV_W  registered {prdata, pslverr}; stable while ack is high
paddrm  out  ADDR_WIDTH  APB address
pwdatam  out  DATA_WIDTH  APB write data
pwritem  out  1  APB write strobe
pselm  out  1  APB select
penablem  out  1  APB enable
prdatam  in  DATA_WIDTH  APB read data
pslverrm  in  1  APB error
preadym  in  1  APB ready

Behaviour:
- Reset (presetm=1 at a pclkm edge): state IDLE, all outputs 0, synchronizer flops 0. Mid-transfer reset aborts with no ack; psel/penable drop on that edge.
- req synchronizer: 2 flops on pclkm, clocked every edge regardless of pclkenm. Output is req_sync.
- FSM state changes happen only on edges where pclkenm=1:
  - IDLE: on req_sync=1, load paddrm/pwdatam/pwritem from fwd data, set pselm=1, go to SETUP.
  - SETUP: set penablem=1, go to ACCESS.
  - ACCESS: on preadym=1, load rev reg with {prdatam,pslverrm}, set ack=1, clear pselm/penablem, go to ACKED. With preadym=0, stay in ACCESS with outputs held (unlimited wait states).
  - ACKED: on req_sync=0, set ack=0, go to IDLE.
- Latency (pclkenm=1 throughout, zero wait states): req edge → ack rise = 2 sync + IDLE + SETUP + ACCESS = 5 pclkm edges. req fall → ack fall = 3 edges.
- Rev data and ack load on the same edge. The slave side gates data with its synchronized ack, so no setup skew arises. Rev data changes only at ACCESS completion and holds until the next transfer.
- APB address/data/write outputs hold their last values in IDLE. pwdatam is don't-care on reads but is still driven from the payload.
- req rising while in ACKED is a protocol violation; it is ignored until ack falls, after which the next transfer proceeds normally.
- pclkenm=0 freezes the FSM and APB/rev registers. The synchronizer keeps sampling.
- Exactly one APB transfer per request; there is no pipelining or back-to-back without a full handshake.

Optional Feature:
CXAPBASYNCBRIDGE_SYNC3_EN: when defined, the req synchronizer has 3 flops and req→ack latency becomes 6 edges (req fall → ack fall 4 edges). When undefined, the synchronizer has 2 flops. The FSM is otherwise identical.

Decomposition:
- Package cxapbasyncbridge_pkg: FSM state encoding (IDLE, SETUP, ACCESS, ACKED), FWD_W/REV_W derivation, payload field offsets (pwrite bit 0, pwdata [DATA_WIDTH:1], paddr upper bits; rev pslverr bit 0, prdata upper bits).
- Sub-module cxapbasyncbridge_master_req_sync: the 2/3-stage reset-to-0 synchronizer, with the stage count selected by the macro.

Test Plan:
- Write, zero wait, pclkenm=1: fwd={0x4000_0010,0xDEAD_BEEF,1}, req↑ → pselm↑ at edge 3, penablem↑ at edge 4, ack↑ at edge 5, rev={x,0}. Drop req → ack↓ 3 edges later.
- Read with 3 wait states, prdatam=0x1234_5678, pslverrm=1 → ack rises 3 edges later than zero-wait; rev=0x2468_ACF1 ({0x12345678,1}); psel/penable held through the waits.
- pclkenm toggling 1/0 each edge during a read → FSM advances only on enabled edges; APB timing is valid relative to enabled edges; rev data correct.
- presetm asserted during ACCESS → next edge: all outputs 0, state IDLE. req still high → new transfer starts once reset is released.
- Two back-to-back requests with different addresses → two distinct APB transfers, ack returns to 0 between them, rev data updates only at each ACCESS completion.
- With CXAPBASYNCBRIDGE_SYNC3_EN defined → zero-wait req↑→ack↑ = 6 edges.

Source files
------------

// File: rtl/cxapbasyncbridge_pkg.sv
// Shared definitions for the APB async bridge: master FSM states and payload layout.
// fwd = {paddr, pwdata, pwrite}; rev = {prdata, pslverr}.
package cxapbasyncbridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACKED  = 2'd3
    } apbm_state_e;

    localparam int FWD_PWRITE_BIT  = 0;
    localparam int FWD_PWDATA_LSB  = 1;
    localparam int REV_PSLVERR_BIT = 0;
    localparam int REV_PRDATA_LSB  = 1;

    function automatic int fwd_width(input int addr_w, input int data_w);
        return addr_w + data_w + 1;
    endfunction

    function automatic int rev_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/cxapbasyncbridge_master_req_sync.sv
// Reset-to-0 synchronizer for the inter-domain request; 2 stages, 3 with CXAPBASYNCBRIDGE_SYNC3_EN.
// Clocks every pclkm edge (ignores the APB clock enable); no backpressure.
module cxapbasyncbridge_master_req_sync (
    input  logic pclkm,
    input  logic presetm,
    input  logic req_i,
    output logic req_sync_o
);

`ifdef CXAPBASYNCBRIDGE_SYNC3_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge pclkm) begin
        if (presetm) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], req_i};
        end
    end

    assign req_sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cxapbasyncbridge_master_domain.sv
// Master half of the APB async bridge: one APB3 transfer per four-phase request, {prdata,pslverr} returned with ack.
// Latency req->ack 5 edges + wait states (6 with CXAPBASYNCBRIDGE_SYNC3_EN); req fall->ack fall 3 (4).
// Backpressure: preadym stretches ACCESS indefinitely; pclkenm=0 freezes FSM and payload registers.
module cxapbasyncbridge_master_domain
    import cxapbasyncbridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int FWD_W = fwd_width(ADDR_WIDTH, DATA_WIDTH),
    localparam int REV_W = rev_width(DATA_WIDTH)
) (
    input  logic                  pclkm,
    input  logic                  presetm,
    input  logic                  pclkenm,
    input  logic                  apbm_req_async,
    input  logic [FWD_W-1:0]      apbm_fwd_data_async,
    output logic                  apbm_ack_async,
    output logic [REV_W-1:0]      apbm_rev_data_async,
    output logic [ADDR_WIDTH-1:0] paddrm,
    output logic [DATA_WIDTH-1:0] pwdatam,
    output logic                  pwritem,
    output logic                  pselm,
    output logic                  penablem,
    input  logic [DATA_WIDTH-1:0] prdatam,
    input  logic                  pslverrm,
    input  logic                  preadym
);

    logic req_sync;

    cxapbasyncbridge_master_req_sync u_req_sync (
        .pclkm      (pclkm),
        .presetm    (presetm),
        .req_i      (apbm_req_async),
        .req_sync_o (req_sync)
    );

    apbm_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  ack_q, ack_d;
    logic [REV_W-1:0]      rev_q, rev_d;

    always_ff @(posedge pclkm) begin
        if (presetm) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= 1'b0;
            rev_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ack_q     <= ack_d;
            rev_q     <= rev_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        ack_d     = ack_q;
        rev_d     = rev_q;
        if (pclkenm) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_sync) begin
                        paddr_d  = apbm_fwd_data_async[FWD_W-1 -: ADDR_WIDTH];
                        pwdata_d = apbm_fwd_data_async[FWD_PWDATA_LSB +: DATA_WIDTH];
                        pwrite_d = apbm_fwd_data_async[FWD_PWRITE_BIT];
                        psel_d   = 1'b1;
                        state_d  = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_d = 1'b1;
                    state_d   = ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Rev data and ack share an edge; the slave side qualifies data with its synced ack.
                    if (preadym) begin
                        rev_d[REV_PRDATA_LSB +: DATA_WIDTH] = prdatam;
                        rev_d[REV_PSLVERR_BIT]              = pslverrm;
                        ack_d     = 1'b1;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        state_d   = ST_ACKED;
                    end
                end
                ST_ACKED: begin
                    if (!req_sync) begin
                        ack_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign apbm_ack_async      = ack_q;
    assign apbm_rev_data_async = rev_q;
    assign paddrm              = paddr_q;
    assign pwdatam             = pwdata_q;
    assign pwritem             = pwrite_q;
    assign pselm               = psel_q;
    assign penablem            = penable_q;

endmodule

// File: tb/tb_cxapbasyncbridge_master_domain.sv
// Scoreboarded bench for cxapbasyncbridge_master_domain: APB slave model, latency and handshake checks.
module tb_cxapbasyncbridge_master_domain;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FW = AW + DW + 1;
    localparam int RW = DW + 1;
`ifdef CXAPBASYNCBRIDGE_SYNC3_EN
    localparam int LAT_RISE = 6;
    localparam int LAT_FALL = 4;
`else
    localparam int LAT_RISE = 5;
    localparam int LAT_FALL = 3;
`endif

    logic          pclkm = 1'b0;
    logic          presetm = 1'b1;
    logic          pclkenm = 1'b1;
    logic          req = 1'b0;
    logic [FW-1:0] fwd = '0;
    logic          ackm;
    logic [RW-1:0] rev;
    logic [AW-1:0] paddrm;
    logic [DW-1:0] pwdatam;
    logic          pwritem, pselm, penablem;
    logic [DW-1:0] prdatam = '0;
    logic          pslverrm = 1'b0;
    logic          preadym = 1'b0;

    cxapbasyncbridge_master_domain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclkm               (pclkm),
        .presetm             (presetm),
        .pclkenm             (pclkenm),
        .apbm_req_async      (req),
        .apbm_fwd_data_async (fwd),
        .apbm_ack_async      (ackm),
        .apbm_rev_data_async (rev),
        .paddrm              (paddrm),
        .pwdatam             (pwdatam),
        .pwritem             (pwritem),
        .pselm               (pselm),
        .penablem            (penablem),
        .prdatam             (prdatam),
        .pslverrm            (pslverrm),
        .preadym             (preadym)
    );

    always #5 pclkm = ~pclkm;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
    } xfer_t;

    xfer_t         apb_q[$];
    logic [RW-1:0] rev_q[$];
    logic [RW-1:0] last_rev = '0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            cur_waits = 0;
    int            wcnt = 0;
    bit            toggle_en = 1'b0;
    logic          ack_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Clock enable: steady 1, or alternating every edge in toggle mode.
    always @(posedge pclkm) begin
        #1;
        pclkenm = toggle_en ? ~pclkenm : 1'b1;
    end

    // APB slave: inserts cur_waits wait states once the transfer reaches ACCESS.
    always @(posedge pclkm) begin
        #1;
        if (pselm && penablem) begin
            if (wcnt >= cur_waits) preadym = 1'b1;
            else begin
                preadym = 1'b0;
                wcnt++;
            end
        end else begin
            preadym = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: APB completions and ack rises are matched against the scoreboard queues.
    always @(negedge pclkm) begin
        if (!presetm && pselm && penablem && preadym && pclkenm) begin
            if (apb_q.size() == 0) check("apb_unexpected", 1, 0);
            else begin
                xfer_t e;
                e = apb_q.pop_front();
                check("paddr", paddrm, e.a);
                check("pwdata", pwdatam, e.d);
                check("pwrite", pwritem, e.w);
            end
        end
        if (ackm && !ack_prev) begin
            if (rev_q.size() == 0) check("ack_unexpected", 1, 0);
            else begin
                logic [RW-1:0] er;
                er = rev_q.pop_front();
                check("rev_data", rev, er);
                last_rev = er;
            end
        end
        ack_prev = ackm;
    end

    task automatic xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                        input int waits, input logic [DW-1:0] prd, input logic perr, input bit tog);
        int n;
        int psel_at;
        int pen_at;
        xfer_t e;
        toggle_en = tog;
        cur_waits = waits;
        prdatam   = prd;
        pslverrm  = perr;
        e.a = a; e.d = d; e.w = w;
        apb_q.push_back(e);
        rev_q.push_back({prd, perr});
        @(posedge pclkm); #1;
        fwd = {a, d, w};
        req = 1'b1;
        n = 0; psel_at = 0; pen_at = 0;
        while (!ackm && n < 300) begin
            @(posedge pclkm); #1;
            n++;
            if (pselm && psel_at == 0) psel_at = n;
            if (penablem && pen_at == 0) pen_at = n;
        end
        if (!ackm) check("ack_rise_timeout", 0, 1);
        else if (!tog) begin
            check("lat_req_to_ack", n, LAT_RISE + waits);
            check("lat_psel", psel_at, LAT_RISE - 2);
            check("lat_penable", pen_at, LAT_RISE - 1);
        end
        @(negedge pclkm);
        req = 1'b0;
        n = 0;
        while (ackm && n < 300) begin
            @(posedge pclkm); #1;
            n++;
        end
        if (ackm) check("ack_fall_timeout", 1, 0);
        else begin
            if (!tog) check("lat_fall", n, LAT_FALL);
            check("rev_hold", rev, last_rev);
            check("psel_idle", {pselm, penablem}, 2'b00);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge pclkm);
        #1;
        check("reset_ack", ackm, 0);
        check("reset_rev", rev, 0);
        check("reset_apb", {paddrm, pwdatam, pwritem, pselm, penablem}, 0);
        presetm = 1'b0;
        repeat (2) @(posedge pclkm);

        // Directed write, zero wait; the half-cycle in xfer makes fall latency measured from a posedge+1 start.
        xfer(32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
        // Directed read, 3 wait states, error response.
        xfer(32'h4000_0020, 32'h0, 1'b0, 3, 32'h1234_5678, 1'b1, 1'b0);
        check("rev_read_err", rev, 33'h0_2468_ACF1);
        // Read with the clock enable toggling.
        xfer(32'h4000_0030, 32'h5555_AAAA, 1'b0, 1, 32'hCAFE_0001, 1'b0, 1'b1);

        // Reset during ACCESS aborts; request still high restarts the same transfer.
        toggle_en = 1'b0;
        cur_waits = 8;
        prdatam = 32'h7777_8888;
        pslverrm = 1'b0;
        begin
            xfer_t e;
            e.a = 32'h4000_0040; e.d = 32'h1111_2222; e.w = 1'b1;
            apb_q.push_back(e);
            rev_q.push_back({32'h7777_8888, 1'b0});
        end
        @(posedge pclkm); #1;
        fwd = {32'h4000_0040, 32'h1111_2222, 1'b1};
        req = 1'b1;
        n = 0;
        while (!penablem && n < 100) begin
            @(posedge pclkm); #1; n++;
        end
        check("reach_access", penablem, 1);
        presetm = 1'b1;
        @(posedge pclkm); #1;
        check("rst_mid_sel", {pselm, penablem, ackm}, 3'b000);
        check("rst_mid_apb", {paddrm, pwdatam, pwritem}, 0);
        check("rst_mid_rev", rev, 0);
        presetm = 1'b0;
        cur_waits = 1;
        n = 0;
        while (!ackm && n < 100) begin
            @(posedge pclkm); #1; n++;
        end
        check("restart_ack", ackm, 1);
        @(negedge pclkm);
        req = 1'b0;
        n = 0;
        while (ackm && n < 100) begin
            @(posedge pclkm); #1; n++;
        end
        check("restart_ack_fall", ackm, 0);

        // Back-to-back requests with different addresses.
        xfer(32'h0000_1000, 32'hA5A5_A5A5, 1'b1, 0, 32'h0000_0001, 1'b0, 1'b0);
        check("ack_low_between", ackm, 0);
        xfer(32'h0000_2000, 32'h5A5A_5A5A, 1'b0, 2, 32'h0000_0002, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            xfer($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                 $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        toggle_en = 1'b0;
        repeat (5) @(posedge pclkm);
        #1;
        check("apb_q_empty", apb_q.size(), 0);
        check("rev_q_empty", rev_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
